// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS control FSM.
//   - state_t  : FSM state encoding (4 bits)
//   - iclass_t : instruction class produced by mc_opcode_class
//   - opcode/funct constants and the control-field codes driven by
//     mc_controller (ALUOp, ALUSrcB, PCSource, RegDst, MemToReg, MemSize)
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EX_R    = 4'd3,
        ST_EX_IMM  = 4'd4,
        ST_EX_ADDR = 4'd5,
        ST_MEM_RD  = 4'd6,
        ST_MEM_WB  = 4'd7,
        ST_MEM_WR  = 4'd8,
        ST_EX_BR   = 4'd9,
        ST_EX_J    = 4'd10,
        ST_WB_R    = 4'd11,
        ST_WB_IMM  = 4'd12,
        ST_FAULT   = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_JR, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JUMP, CL_JAL, CL_IMM, CL_ILLEGAL
    } iclass_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001; // bgez / bltz
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_JR     = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] MSIZE_WORD = 2'b00;
    localparam logic [1:0] MSIZE_HALF = 2'b01;
    localparam logic [1:0] MSIZE_BYTE = 2'b10;

endpackage

// File: rtl/mc_opcode_class.sv
// mc_opcode_class: combinational instruction classifier.
//   i_opcode  [5:0] : IR[31:26]
//   i_funct   [5:0] : IR[5:0] (only jr is distinguished among R-types)
//   o_class         : RTYPE/JR/LOAD/STORE/BRANCH/JUMP/JAL/IMM/ILLEGAL
//   o_mem_size[1:0] : access width for loads/stores, word otherwise
module mc_opcode_class
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output iclass_t    o_class,
    output logic [1:0] o_mem_size
);

    always_comb begin
        o_class    = CL_ILLEGAL;
        o_mem_size = MSIZE_WORD;
        unique case (i_opcode)
            OP_RTYPE:                 o_class = (i_funct == FN_JR) ? CL_JR : CL_RTYPE;
            OP_LW:                    o_class = CL_LOAD;
            OP_LH: begin              o_class = CL_LOAD;  o_mem_size = MSIZE_HALF; end
            OP_LB: begin              o_class = CL_LOAD;  o_mem_size = MSIZE_BYTE; end
            OP_SW:                    o_class = CL_STORE;
            OP_SH: begin              o_class = CL_STORE; o_mem_size = MSIZE_HALF; end
            OP_SB: begin              o_class = CL_STORE; o_mem_size = MSIZE_BYTE; end
            OP_BEQ, OP_BNE, OP_REGIMM,
            OP_BGTZ, OP_BLEZ:         o_class = CL_BRANCH;
            OP_J:                     o_class = CL_JUMP;
            OP_JAL:                   o_class = CL_JAL;
            OP_ADDI, OP_ANDI, OP_ORI,
            OP_SLTI, OP_XORI:         o_class = CL_IMM;
            default:                  o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM (fetch/decode/execute/mem/wb)
// sharing one ALU and one memory port, with a req/ready memory handshake
// and a wait-cycle timeout that parks the FSM in a sticky FAULT state.
//   Clk, Rst (async, active-low)
//   OpCode, Funct, BranchTaken, MemReady           : datapath inputs
//   PCWrite, IRWrite, IorD, MemRead, MemWrite,
//   MemSize, RegDst, MemToReg, RegWrite, ALUSrcA,
//   ALUSrcB, ALUOp, PCSource                       : datapath controls
//   Fault                                          : sticky error flag
// Optional build macro MC_CTRL_PERF_EN adds CycleCount/InstrCount outputs.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       BranchTaken,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemSize,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Fault
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] CycleCount,
    output logic [31:0] InstrCount
`endif
);

    localparam logic [7:0] TIMEOUT8 = 8'(MEM_TIMEOUT);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_wait_cnt, w_wait_nxt;
    iclass_t    w_class;
    logic [1:0] w_mem_size;

    mc_opcode_class u_class (
        .i_opcode   (OpCode),
        .i_funct    (Funct),
        .o_class    (w_class),
        .o_mem_size (w_mem_size)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = '0;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemSize     = MSIZE_WORD;
        RegDst      = REGDST_RT;
        MemToReg    = M2R_ALUOUT;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        Fault       = 1'b0;

        // Memory states share the timeout rule: MemReady takes priority over
        // the wait that would make the count reach MEM_TIMEOUT.
        if (r_state == ST_FETCH || r_state == ST_MEM_RD || r_state == ST_MEM_WR) begin
            if (!MemReady) begin
                if (r_wait_cnt + 8'd1 >= TIMEOUT8)
                    w_state_nxt = ST_FAULT;
                else
                    w_wait_nxt = r_wait_cnt + 8'd1;
            end
        end

        unique case (r_state)
            ST_IDLE: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemReady) begin
                    IRWrite     = 1'b1;
                    PCWrite     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMM_SL2;
                unique case (w_class)
                    CL_RTYPE:          w_state_nxt = ST_EX_R;
                    CL_JR:             w_state_nxt = ST_EX_J;
                    CL_LOAD, CL_STORE: w_state_nxt = ST_EX_ADDR;
                    CL_BRANCH:         w_state_nxt = ST_EX_BR;
                    CL_JUMP, CL_JAL:   w_state_nxt = ST_EX_J;
                    CL_IMM:            w_state_nxt = ST_EX_IMM;
                    default:           w_state_nxt = ST_FAULT;
                endcase
            end
            ST_EX_R: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_FUNCT;
                w_state_nxt = ST_WB_R;
            end
            ST_EX_IMM: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALUOp       = (OpCode == OP_ADDI) ? ALUOP_ADD : ALUOP_IMM;
                w_state_nxt = ST_WB_IMM;
            end
            ST_EX_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                w_state_nxt = (w_class == CL_STORE) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                MemSize = w_mem_size;
                if (MemReady) w_state_nxt = ST_MEM_WB;
            end
            ST_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                MemSize  = w_mem_size;
                if (MemReady) w_state_nxt = ST_FETCH;
            end
            ST_MEM_WB: begin
                RegWrite    = 1'b1;
                MemToReg    = M2R_MDR;
                w_state_nxt = ST_FETCH;
            end
            ST_EX_BR: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWrite     = BranchTaken;
                PCSource    = PCSRC_ALUOUT;
                w_state_nxt = ST_FETCH;
            end
            ST_EX_J: begin
                PCWrite  = 1'b1;
                PCSource = (w_class == CL_JR) ? PCSRC_RS : PCSRC_JUMP;
                if (w_class == CL_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = REGDST_RA;
                    MemToReg = M2R_PC;
                end
                w_state_nxt = ST_FETCH;
            end
            ST_WB_R: begin
                RegWrite    = 1'b1;
                RegDst      = REGDST_RD;
                w_state_nxt = ST_FETCH;
            end
            ST_WB_IMM: begin
                RegWrite    = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_FAULT: begin
                Fault       = 1'b1;
                w_state_nxt = ST_FAULT;
            end
            default: w_state_nxt = ST_FAULT;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt, r_instr_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != ST_IDLE && r_state != ST_FAULT)
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            // IDLE->FETCH and FETCH wait cycles are not instruction completions.
            if (w_state_nxt == ST_FETCH && r_state != ST_FETCH && r_state != ST_IDLE)
                r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign CycleCount = r_cycle_cnt;
    assign InstrCount = r_instr_cnt;
`endif

endmodule
